// File: rtl/target_addr_bank.sv
// Per-target dynamic-address, limit and bus-lookup state for NUM_TARGETS target personalities.
// Define TARGET_ADDR_CONFLICT_EN to build the pairwise address-collision scanner.
module target_addr_bank #(
    parameter int unsigned NUM_TARGETS  = 2,
    parameter logic [15:0] DEFAULT_MWL  = 16'd256,
    parameter logic [15:0] DEFAULT_MRL  = 16'd256,
    parameter logic [7:0]  DEFAULT_IBIL = 8'd255,
    localparam int unsigned IW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [7*NUM_TARGETS-1:0]   sta_addr_i,
    input  logic [NUM_TARGETS-1:0]     sta_addr_valid_i,
    input  logic [NUM_TARGETS-1:0]     csr_dyn_wr_i,
    input  logic [7*NUM_TARGETS-1:0]   csr_dyn_addr_i,
    input  logic [NUM_TARGETS-1:0]     csr_dyn_valid_i,
    input  logic                       ccc_set_dyn_i,
    input  logic [IW-1:0]              ccc_tgt_i,
    input  logic [6:0]                 ccc_dyn_addr_i,
    input  logic                       ccc_rstdaa_i,
    input  logic                       set_mwl_i,
    input  logic                       set_mrl_i,
    input  logic                       set_ibil_i,
    input  logic [15:0]                mwl_i,
    input  logic [15:0]                mrl_i,
    input  logic [7:0]                 ibil_i,
    input  logic                       match_req_i,
    input  logic [6:0]                 match_addr_i,
    output logic                       match_ack_o,
    output logic                       match_hit_o,
    output logic [IW-1:0]              match_idx_o,
    output logic                       match_is_dyn_o,
    output logic                       match_bcast_o,
    output logic [7*NUM_TARGETS-1:0]   dyn_addr_o,
    output logic [NUM_TARGETS-1:0]     dyn_addr_valid_o,
    output logic [NUM_TARGETS-1:0]     dyn_upd_o,
    output logic [7*NUM_TARGETS-1:0]   ibi_addr_o,
    output logic [16*NUM_TARGETS-1:0]  get_mwl_o,
    output logic [16*NUM_TARGETS-1:0]  get_mrl_o,
    output logic [8*NUM_TARGETS-1:0]   get_ibil_o,
    output logic                       conflict_o,
    input  logic                       conflict_clr_i
);
    localparam int unsigned N = NUM_TARGETS;

    logic [N-1:0][6:0]  sta_addr, csr_addr, dyn_addr_q, dyn_addr_d, ibi_addr, cand_addr;
    logic [N-1:0]       dyn_valid_q, dyn_valid_d, dyn_upd_q, dyn_upd_d, cand_valid;
    logic [N-1:0][15:0] mwl_q, mwl_d, mrl_q, mrl_d;
    logic [N-1:0][7:0]  ibil_q, ibil_d;
    logic               match_ack_q, match_ack_d, match_hit_q, match_hit_d;
    logic               match_is_dyn_q, match_is_dyn_d, match_bcast_q, match_bcast_d;
    logic [IW-1:0]      match_idx_q, match_idx_d;
    logic               found, found_dyn;
    logic [IW-1:0]      found_idx;

    assign sta_addr = sta_addr_i;
    assign csr_addr = csr_dyn_addr_i;

    always_comb begin
        dyn_addr_d  = dyn_addr_q;
        dyn_valid_d = dyn_valid_q;
        dyn_upd_d   = '0;
        mwl_d       = mwl_q;
        mrl_d       = mrl_q;
        ibil_d      = ibil_q;
        for (int k = 0; k < int'(N); k++) begin
            // Out-of-range indices never compare equal, so those pulses are dropped.
            if (csr_dyn_wr_i[k]) begin
                dyn_addr_d[k]  = csr_addr[k];
                dyn_valid_d[k] = csr_dyn_valid_i[k];
            end else if (ccc_set_dyn_i && int'(ccc_tgt_i) == k) begin
                dyn_addr_d[k]  = ccc_dyn_addr_i;
                dyn_valid_d[k] = 1'b1;
            end else if (ccc_rstdaa_i) begin
                dyn_valid_d[k] = 1'b0;
            end
            dyn_upd_d[k] = (ccc_set_dyn_i && int'(ccc_tgt_i) == k) || ccc_rstdaa_i;
            if (set_mwl_i && int'(ccc_tgt_i) == k) mwl_d[k] = mwl_i;
            if (set_mrl_i && int'(ccc_tgt_i) == k) mrl_d[k] = mrl_i;
            if (set_ibil_i && int'(ccc_tgt_i) == k) ibil_d[k] = ibil_i;
        end
    end

    always_comb begin
        found     = 1'b0;
        found_dyn = 1'b0;
        found_idx = '0;
        for (int k = 0; k < int'(N); k++) begin
            cand_valid[k] = dyn_valid_q[k] | sta_addr_valid_i[k];
            cand_addr[k]  = dyn_valid_q[k] ? dyn_addr_q[k] :
                            (sta_addr_valid_i[k] ? sta_addr[k] : 7'h00);
            ibi_addr[k]   = dyn_valid_q[k] ? dyn_addr_q[k] : sta_addr[k];
            if (!found && cand_valid[k] && cand_addr[k] == match_addr_i) begin
                found     = 1'b1;
                found_dyn = dyn_valid_q[k];
                found_idx = IW'(k);
            end
        end
    end

    always_comb begin
        match_ack_d    = 1'b0;
        match_hit_d    = match_hit_q;
        match_idx_d    = match_idx_q;
        match_is_dyn_d = match_is_dyn_q;
        match_bcast_d  = match_bcast_q;
        if (match_req_i) begin
            match_ack_d    = 1'b1;
            match_bcast_d  = (match_addr_i == 7'h7E);
            match_hit_d    = found && !match_bcast_d;
            match_idx_d    = match_hit_d ? found_idx : '0;
            match_is_dyn_d = match_hit_d && found_dyn;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            dyn_addr_q     <= '0;
            dyn_valid_q    <= '0;
            dyn_upd_q      <= '0;
            mwl_q          <= {N{DEFAULT_MWL}};
            mrl_q          <= {N{DEFAULT_MRL}};
            ibil_q         <= {N{DEFAULT_IBIL}};
            match_ack_q    <= 1'b0;
            match_hit_q    <= 1'b0;
            match_idx_q    <= '0;
            match_is_dyn_q <= 1'b0;
            match_bcast_q  <= 1'b0;
        end else begin
            dyn_addr_q     <= dyn_addr_d;
            dyn_valid_q    <= dyn_valid_d;
            dyn_upd_q      <= dyn_upd_d;
            mwl_q          <= mwl_d;
            mrl_q          <= mrl_d;
            ibil_q         <= ibil_d;
            match_ack_q    <= match_ack_d;
            match_hit_q    <= match_hit_d;
            match_idx_q    <= match_idx_d;
            match_is_dyn_q <= match_is_dyn_d;
            match_bcast_q  <= match_bcast_d;
        end
    end

    assign match_ack_o      = match_ack_q;
    assign match_hit_o      = match_hit_q;
    assign match_idx_o      = match_idx_q;
    assign match_is_dyn_o   = match_is_dyn_q;
    assign match_bcast_o    = match_bcast_q;
    assign dyn_addr_o       = dyn_addr_q;
    assign dyn_addr_valid_o = dyn_valid_q;
    assign dyn_upd_o        = dyn_upd_q;
    assign ibi_addr_o       = ibi_addr;
    assign get_mwl_o        = mwl_q;
    assign get_mrl_o        = mrl_q;
    assign get_ibil_o       = ibil_q;

`ifdef TARGET_ADDR_CONFLICT_EN
    typedef enum logic [0:0] {StIdle, StScan} scan_state_e;

    scan_state_e        state_q, state_d;
    logic [IW-1:0]      pi_q, pi_d, pj_q, pj_d;
    logic [N-1:0][6:0]  cand_addr_q;
    logic [N-1:0]       cand_valid_q;
    logic               conflict_q, conflict_d, cand_changed;

    assign cand_changed = (cand_addr != cand_addr_q) || (cand_valid != cand_valid_q);

    always_comb begin
        state_d    = state_q;
        pi_d       = pi_q;
        pj_d       = pj_q;
        conflict_d = conflict_clr_i ? 1'b0 : conflict_q;
        if (N > 1) begin
            if (cand_changed) begin
                state_d = StScan;
                pi_d    = '0;
                pj_d    = IW'(1);
            end else if (state_q == StScan) begin
                // Detection overrides a same-cycle clear.
                if (cand_valid[pi_q] && cand_valid[pj_q] && cand_addr[pi_q] == cand_addr[pj_q]) begin
                    conflict_d = 1'b1;
                end
                if (int'(pj_q) == int'(N) - 1) begin
                    if (int'(pi_q) == int'(N) - 2) begin
                        state_d = StIdle;
                    end else begin
                        pi_d = pi_q + IW'(1);
                        pj_d = pi_q + IW'(2);
                    end
                end else begin
                    pj_d = pj_q + IW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            pi_q         <= '0;
            pj_q         <= '0;
            cand_addr_q  <= '0;
            cand_valid_q <= '0;
            conflict_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pi_q         <= pi_d;
            pj_q         <= pj_d;
            cand_addr_q  <= cand_addr;
            cand_valid_q <= cand_valid;
            conflict_q   <= conflict_d;
        end
    end

    assign conflict_o = conflict_q;
`else
    logic unused_conflict_clr;
    assign unused_conflict_clr = conflict_clr_i;
    assign conflict_o = 1'b0;
`endif

endmodule

// File: tb/tb_target_addr_bank.sv
// Directed bench: a 2-target instance for lookup/update/limit behaviour and a 3-target
// instance for out-of-range indices and the collision scanner.
module tb_target_addr_bank;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // 2-target instance
    logic [13:0] sta_addr, csr_addr, dyn_addr, ibi_addr;
    logic [1:0]  sta_valid, csr_wr, csr_valid, dyn_valid, dyn_upd;
    logic        ccc_set, rstdaa, set_mwl, set_mrl, set_ibil, req, clr;
    logic [0:0]  ccc_tgt, idx;
    logic [6:0]  ccc_addr, maddr;
    logic [15:0] mwl, mrl, gibil;
    logic [7:0]  ibil;
    logic        ack, hit, is_dyn, bcast, conflict;
    logic [31:0] gmwl, gmrl;

    // 3-target instance
    logic [20:0] b_sta_addr, b_csr_addr, b_dyn_addr, b_ibi_addr;
    logic [2:0]  b_sta_valid, b_csr_wr, b_csr_valid, b_dyn_valid, b_dyn_upd;
    logic        b_ccc_set, b_rstdaa, b_set_mwl, b_set_mrl, b_set_ibil, b_req, b_clr;
    logic [1:0]  b_ccc_tgt, b_idx;
    logic [6:0]  b_ccc_addr, b_maddr;
    logic [15:0] b_mwl, b_mrl;
    logic [7:0]  b_ibil;
    logic        b_ack, b_hit, b_is_dyn, b_bcast, b_conflict;
    logic [47:0] b_gmwl, b_gmrl;
    logic [23:0] b_gibil;
    logic        seen;

    target_addr_bank #(.NUM_TARGETS(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .sta_addr_i(sta_addr), .sta_addr_valid_i(sta_valid),
        .csr_dyn_wr_i(csr_wr), .csr_dyn_addr_i(csr_addr), .csr_dyn_valid_i(csr_valid),
        .ccc_set_dyn_i(ccc_set), .ccc_tgt_i(ccc_tgt), .ccc_dyn_addr_i(ccc_addr),
        .ccc_rstdaa_i(rstdaa), .set_mwl_i(set_mwl), .set_mrl_i(set_mrl), .set_ibil_i(set_ibil),
        .mwl_i(mwl), .mrl_i(mrl), .ibil_i(ibil), .match_req_i(req), .match_addr_i(maddr),
        .match_ack_o(ack), .match_hit_o(hit), .match_idx_o(idx), .match_is_dyn_o(is_dyn),
        .match_bcast_o(bcast), .dyn_addr_o(dyn_addr), .dyn_addr_valid_o(dyn_valid),
        .dyn_upd_o(dyn_upd), .ibi_addr_o(ibi_addr), .get_mwl_o(gmwl), .get_mrl_o(gmrl),
        .get_ibil_o(gibil), .conflict_o(conflict), .conflict_clr_i(clr)
    );

    target_addr_bank #(.NUM_TARGETS(3)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .sta_addr_i(b_sta_addr), .sta_addr_valid_i(b_sta_valid),
        .csr_dyn_wr_i(b_csr_wr), .csr_dyn_addr_i(b_csr_addr), .csr_dyn_valid_i(b_csr_valid),
        .ccc_set_dyn_i(b_ccc_set), .ccc_tgt_i(b_ccc_tgt), .ccc_dyn_addr_i(b_ccc_addr),
        .ccc_rstdaa_i(b_rstdaa), .set_mwl_i(b_set_mwl), .set_mrl_i(b_set_mrl),
        .set_ibil_i(b_set_ibil), .mwl_i(b_mwl), .mrl_i(b_mrl), .ibil_i(b_ibil),
        .match_req_i(b_req), .match_addr_i(b_maddr), .match_ack_o(b_ack), .match_hit_o(b_hit),
        .match_idx_o(b_idx), .match_is_dyn_o(b_is_dyn), .match_bcast_o(b_bcast),
        .dyn_addr_o(b_dyn_addr), .dyn_addr_valid_o(b_dyn_valid), .dyn_upd_o(b_dyn_upd),
        .ibi_addr_o(b_ibi_addr), .get_mwl_o(b_gmwl), .get_mrl_o(b_gmrl), .get_ibil_o(b_gibil),
        .conflict_o(b_conflict), .conflict_clr_i(b_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input logic [6:0] a);
        req = 1'b1;
        maddr = a;
        tick();
        req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        sta_addr = '0; sta_valid = '0; csr_wr = '0; csr_addr = '0; csr_valid = '0;
        ccc_set = 0; ccc_tgt = '0; ccc_addr = '0; rstdaa = 0; set_mwl = 0; set_mrl = 0;
        set_ibil = 0; mwl = '0; mrl = '0; ibil = '0; req = 0; maddr = '0; clr = 0;
        b_sta_addr = '0; b_sta_valid = '0; b_csr_wr = '0; b_csr_addr = '0; b_csr_valid = '0;
        b_ccc_set = 0; b_ccc_tgt = '0; b_ccc_addr = '0; b_rstdaa = 0; b_set_mwl = 0;
        b_set_mrl = 0; b_set_ibil = 0; b_mwl = '0; b_mrl = '0; b_ibil = '0; b_req = 0;
        b_maddr = '0; b_clr = 0; seen = 0;
        tick();
        tick();
        rst_n = 1'b1;

        chk("rst_mwl", 64'(gmwl), 64'h0100_0100);
        chk("rst_mrl", 64'(gmrl), 64'h0100_0100);
        chk("rst_ibil", 64'(gibil), 64'hFFFF);
        chk("rst_dyn_valid", 64'(dyn_valid), 64'h0);
        chk("rst_ack", 64'(ack), 64'h0);
        chk("rst_match", 64'({hit, idx, is_dyn, bcast}), 64'h0);
        chk("rst_upd", 64'(dyn_upd), 64'h0);
        chk("rst_conflict", 64'(conflict), 64'h0);

        // SETDASA t1 -> 0x45 with statics t0=0x30, t1=0x31
        sta_addr = {7'h31, 7'h30};
        sta_valid = 2'b11;
        ccc_set = 1; ccc_tgt = 1'b1; ccc_addr = 7'h45;
        tick();
        ccc_set = 0;
        chk("setdasa_upd", 64'(dyn_upd), 64'h2);
        chk("setdasa_valid", 64'(dyn_valid), 64'h2);
        chk("setdasa_addr1", 64'(dyn_addr[13:7]), 64'h45);
        chk("ibi_addr", 64'(ibi_addr), 64'({7'h45, 7'h30}));
        tick();
        chk("upd_pulse_end", 64'(dyn_upd), 64'h0);

        lookup(7'h31);
        chk("lk31_ack", 64'(ack), 64'h1);
        chk("lk31_hit", 64'({hit, bcast}), 64'h0);
        lookup(7'h45);
        chk("lk45", 64'({ack, hit, idx, is_dyn, bcast}), 64'b11110);
        tick();
        chk("idle_hold", 64'({ack, hit, idx, is_dyn, bcast}), 64'b01110);
        lookup(7'h30);
        chk("lk30", 64'({ack, hit, idx, is_dyn, bcast}), 64'b11000);
        lookup(7'h7E);
        chk("lk_bcast", 64'({ack, hit, bcast}), 64'b101);

        // Lookup in the same cycle as the assignment sees the old state
        ccc_set = 1; ccc_tgt = 1'b0; ccc_addr = 7'h22;
        lookup(7'h22);
        ccc_set = 0;
        chk("same_cycle_miss", 64'({ack, hit}), 64'b10);
        lookup(7'h22);
        chk("next_cycle_hit", 64'({ack, hit, idx, is_dyn}), 64'b1101);

        // RSTDAA with a concurrent software write to t0
        rstdaa = 1;
        csr_wr = 2'b01; csr_addr = {7'h00, 7'h50}; csr_valid = 2'b01;
        tick();
        rstdaa = 0; csr_wr = '0;
        chk("rstdaa_valid", 64'(dyn_valid), 64'h1);
        chk("rstdaa_addr", 64'(dyn_addr), 64'({7'h45, 7'h50}));
        chk("rstdaa_upd", 64'(dyn_upd), 64'h3);
        chk("rstdaa_ibi", 64'(ibi_addr), 64'({7'h31, 7'h50}));

        // Software-only write: no interrupt pulse; both targets at 0x50, lowest wins
        csr_wr = 2'b10; csr_addr = {7'h50, 7'h00}; csr_valid = 2'b10;
        tick();
        csr_wr = '0;
        chk("sw_no_upd", 64'(dyn_upd), 64'h0);
        lookup(7'h50);
        chk("lowest_wins", 64'({hit, idx, is_dyn}), 64'b101);

        // Limits
        set_mrl = 1; ccc_tgt = 1'b1; mrl = 16'd64;
        tick();
        set_mrl = 0;
        chk("mrl_t1", 64'(gmrl), 64'h0040_0100);
        chk("mwl_keep", 64'(gmwl), 64'h0100_0100);
        set_ibil = 1; ccc_tgt = 1'b0; ibil = 8'd10;
        tick();
        set_ibil = 0;
        chk("ibil_t0", 64'(gibil), 64'hFF0A);

        // Out-of-range target index on the 3-target instance
        b_set_mwl = 1; b_ccc_tgt = 2'd3; b_mwl = 16'd999;
        b_ccc_set = 1; b_ccc_addr = 7'h12;
        tick();
        b_set_mwl = 0; b_ccc_set = 0;
        chk("oor_mwl", 64'(b_gmwl), 64'h0100_0100_0100);
        chk("oor_dyn", 64'({b_dyn_valid, b_dyn_upd}), 64'h0);

        // Collision: t2 dynamic equal to t0 static
        b_sta_addr = {7'h32, 7'h31, 7'h30};
        b_sta_valid = 3'b001;
        for (int i = 0; i < 10; i++) tick();
        chk("no_conflict", 64'(b_conflict), 64'h0);
        b_ccc_set = 1; b_ccc_tgt = 2'd2; b_ccc_addr = 7'h30;
        tick();
        b_ccc_set = 0;
        for (int i = 0; i < 7; i++) begin
            if (b_conflict) seen = 1;
            if (!seen) tick();
        end
        if (b_conflict) seen = 1;
`ifdef TARGET_ADDR_CONFLICT_EN
        chk("conflict_rise", 64'(seen), 64'h1);
`else
        chk("conflict_off", 64'(seen), 64'h0);
`endif
        b_clr = 1;
        tick();
        b_clr = 0;
        chk("conflict_clr", 64'(b_conflict), 64'h0);
        b_rstdaa = 1;
        tick();
        b_rstdaa = 0;
        for (int i = 0; i < 8; i++) tick();
        chk("conflict_stay0", 64'(b_conflict), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
